// File: rtl/radix_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : radix_dispatcher
// Brief    : In-order request queue feeding three radix units; results retire
//            strictly in issue order through a single output register.
// Revision : 1.0 - initial release
// ============================================================================
module radix_dispatcher #(
    parameter int DATA_W = 16,
    parameter int QDEPTH = 4,
    parameter int TAG_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [1:0]                in_cond_sel,
    input  logic [3:0]                in_opcode,
    input  logic [DATA_W-1:0]         in_a,
    input  logic [DATA_W-1:0]         in_b,
    input  logic [TAG_W-1:0]          in_tag,
    output logic [2:0]                u_start,
    output logic [3:0]                u_opcode,
    output logic [DATA_W-1:0]         u_a,
    output logic [DATA_W-1:0]         u_b,
    input  logic [2:0]                u_busy,
    input  logic [2:0]                u_done,
    input  logic [6*DATA_W-1:0]       u_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [2*DATA_W-1:0]       out_result,
    output logic [TAG_W-1:0]          out_tag,
    output logic [1:0]                out_unit,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic                      busy,
    output logic                      err_spurious
);
    localparam int NUM_UNITS = 3;
    localparam int RES_W     = 2 * DATA_W;
    localparam int PW        = $clog2(QDEPTH);
    localparam int CW        = PW + 1;
    localparam int ODEPTH    = 4;

    logic [1:0]           cond_mem_q [QDEPTH];
    logic [1:0]           cond_mem_d [QDEPTH];
    logic [3:0]           op_mem_q   [QDEPTH];
    logic [3:0]           op_mem_d   [QDEPTH];
    logic [DATA_W-1:0]    a_mem_q    [QDEPTH];
    logic [DATA_W-1:0]    a_mem_d    [QDEPTH];
    logic [DATA_W-1:0]    b_mem_q    [QDEPTH];
    logic [DATA_W-1:0]    b_mem_d    [QDEPTH];
    logic [TAG_W-1:0]     tag_mem_q  [QDEPTH];
    logic [TAG_W-1:0]     tag_mem_d  [QDEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic [1:0]           ord_mem_q [ODEPTH];
    logic [1:0]           ord_mem_d [ODEPTH];
    logic [1:0]           ord_wr_q, ord_wr_d, ord_rd_q, ord_rd_d;
    logic [2:0]           ord_cnt_q, ord_cnt_d;

    logic [NUM_UNITS-1:0] pending_q, pending_d, have_q, have_d;
    logic [RES_W-1:0]     hold_q    [NUM_UNITS];
    logic [RES_W-1:0]     hold_d    [NUM_UNITS];
    logic [TAG_W-1:0]     tag_reg_q [NUM_UNITS];
    logic [TAG_W-1:0]     tag_reg_d [NUM_UNITS];
    logic                 err_q, err_d;

    logic [2:0]           u_start_q, u_start_d;
    logic [3:0]           u_opcode_q, u_opcode_d;
    logic [DATA_W-1:0]    u_a_q, u_a_d, u_b_q, u_b_d;
    logic                 out_valid_q, out_valid_d;
    logic [RES_W-1:0]     out_result_q, out_result_d;
    logic [TAG_W-1:0]     out_tag_q, out_tag_d;
    logic [1:0]           out_unit_q, out_unit_d;

    logic [1:0]           w_head_cond, w_target, w_ord_head;
    logic [3:0]           w_head_op;
    logic                 w_accept, w_dispatch, w_retire;

    // Routing looks only at the queued head entry, never at the live inputs.
    always_comb begin
        w_head_cond = cond_mem_q[rd_ptr_q];
        w_head_op   = op_mem_q[rd_ptr_q];
        if (w_head_cond != 2'd3)
            w_target = w_head_cond;
        else if (w_head_op <= 4'd2)
            w_target = 2'd0;
        else if (w_head_op <= 4'd5)
            w_target = 2'd1;
        else
            w_target = 2'd2;
        w_ord_head = ord_mem_q[ord_rd_q];
        w_accept   = in_valid && in_ready;
        w_dispatch = (cnt_q != '0) && !pending_q[w_target] && !u_busy[w_target]
                     && (ord_cnt_q != 3'(ODEPTH));
        w_retire   = (ord_cnt_q != 3'd0) && have_q[w_ord_head]
                     && (!out_valid_q || out_ready);
    end

    always_comb begin
        cond_mem_d = cond_mem_q;
        op_mem_d   = op_mem_q;
        a_mem_d    = a_mem_q;
        b_mem_d    = b_mem_q;
        tag_mem_d  = tag_mem_q;
        wr_ptr_d   = wr_ptr_q + PW'(w_accept);
        rd_ptr_d   = rd_ptr_q + PW'(w_dispatch);
        cnt_d      = cnt_q + CW'(w_accept) - CW'(w_dispatch);
        if (w_accept) begin
            cond_mem_d[wr_ptr_q] = in_cond_sel;
            op_mem_d[wr_ptr_q]   = in_opcode;
            a_mem_d[wr_ptr_q]    = in_a;
            b_mem_d[wr_ptr_q]    = in_b;
            tag_mem_d[wr_ptr_q]  = in_tag;
        end
        if (rst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    always_comb begin
        ord_mem_d  = ord_mem_q;
        ord_wr_d   = ord_wr_q + 2'(w_dispatch);
        ord_rd_d   = ord_rd_q + 2'(w_retire);
        ord_cnt_d  = ord_cnt_q + 3'(w_dispatch) - 3'(w_retire);
        pending_d  = pending_q;
        have_d     = have_q;
        hold_d     = hold_q;
        tag_reg_d  = tag_reg_q;
        err_d      = err_q;
        u_start_d  = '0;
        u_opcode_d = u_opcode_q;
        u_a_d      = u_a_q;
        u_b_d      = u_b_q;
        for (int i = 0; i < NUM_UNITS; i++) begin
            if (u_done[i]) begin
                if (pending_q[i] && !have_q[i]) begin
                    hold_d[i] = u_result[i*RES_W +: RES_W];
                    have_d[i] = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
        // A retiring unit always has have=1, so it cannot collide with a capture.
        if (w_retire) begin
            pending_d[w_ord_head] = 1'b0;
            have_d[w_ord_head]    = 1'b0;
        end
        if (w_dispatch) begin
            u_start_d[w_target]  = 1'b1;
            u_opcode_d           = w_head_op;
            u_a_d                = a_mem_q[rd_ptr_q];
            u_b_d                = b_mem_q[rd_ptr_q];
            pending_d[w_target]  = 1'b1;
            tag_reg_d[w_target]  = tag_mem_q[rd_ptr_q];
            ord_mem_d[ord_wr_q]  = w_target;
        end
        if (rst) begin
            ord_wr_d   = '0;
            ord_rd_d   = '0;
            ord_cnt_d  = '0;
            pending_d  = '0;
            have_d     = '0;
            err_d      = 1'b0;
            u_start_d  = '0;
            u_opcode_d = '0;
            u_a_d      = '0;
            u_b_d      = '0;
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;
        out_unit_d   = out_unit_q;
        if (w_retire) begin
            out_valid_d  = 1'b1;
            out_result_d = hold_q[w_ord_head];
            out_tag_d    = tag_reg_q[w_ord_head];
            out_unit_d   = w_ord_head;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (rst) begin
            out_valid_d  = 1'b0;
            out_result_d = '0;
            out_tag_d    = '0;
            out_unit_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        cond_mem_q   <= cond_mem_d;
        op_mem_q     <= op_mem_d;
        a_mem_q      <= a_mem_d;
        b_mem_q      <= b_mem_d;
        tag_mem_q    <= tag_mem_d;
        wr_ptr_q     <= wr_ptr_d;
        rd_ptr_q     <= rd_ptr_d;
        cnt_q        <= cnt_d;
        ord_mem_q    <= ord_mem_d;
        ord_wr_q     <= ord_wr_d;
        ord_rd_q     <= ord_rd_d;
        ord_cnt_q    <= ord_cnt_d;
        pending_q    <= pending_d;
        have_q       <= have_d;
        hold_q       <= hold_d;
        tag_reg_q    <= tag_reg_d;
        err_q        <= err_d;
        u_start_q    <= u_start_d;
        u_opcode_q   <= u_opcode_d;
        u_a_q        <= u_a_d;
        u_b_q        <= u_b_d;
        out_valid_q  <= out_valid_d;
        out_result_q <= out_result_d;
        out_tag_q    <= out_tag_d;
        out_unit_q   <= out_unit_d;
    end

    assign in_ready     = (cnt_q != CW'(QDEPTH));
    assign q_count      = cnt_q;
    assign u_start      = u_start_q;
    assign u_opcode     = u_opcode_q;
    assign u_a          = u_a_q;
    assign u_b          = u_b_q;
    assign out_valid    = out_valid_q;
    assign out_result   = out_result_q;
    assign out_tag      = out_tag_q;
    assign out_unit     = out_unit_q;
    assign err_spurious = err_q;
    assign busy         = (cnt_q != '0) || (pending_q != '0) || out_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_radix_dispatcher.sv
`default_nettype none
// ============================================================================
// Module   : tb_radix_dispatcher
// Brief    : Directed and randomized checks of radix_dispatcher against a
//            queue-based behavioural model with stub radix units.
// Revision : 1.0 - initial release
// ============================================================================
module tb_radix_dispatcher;
    localparam int DATA_W = 16;
    localparam int QDEPTH = 4;
    localparam int TAG_W  = 4;
    localparam int RES_W  = 32;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, busy, err_spurious;
    logic [1:0]  in_cond_sel, out_unit;
    logic [3:0]  in_opcode, in_tag, u_opcode, out_tag;
    logic [15:0] in_a, in_b, u_a, u_b;
    logic [2:0]  u_start, u_busy, u_done, q_count;
    logic [95:0] u_result;
    logic [31:0] out_result;

    always #5 clk = ~clk;

    radix_dispatcher #(.DATA_W(DATA_W), .QDEPTH(QDEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_cond_sel(in_cond_sel), .in_opcode(in_opcode), .in_a(in_a), .in_b(in_b),
        .in_tag(in_tag), .u_start(u_start), .u_opcode(u_opcode), .u_a(u_a), .u_b(u_b),
        .u_busy(u_busy), .u_done(u_done), .u_result(u_result), .out_valid(out_valid),
        .out_ready(out_ready), .out_result(out_result), .out_tag(out_tag),
        .out_unit(out_unit), .q_count(q_count), .busy(busy), .err_spurious(err_spurious)
    );

    typedef struct {
        logic [1:0]  cond;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  tag;
    } req_t;

    // Behavioural model state
    req_t        mq[$];
    int          mord[$];
    logic [2:0]  mpend, mhave, mu_start;
    logic [31:0] mhold[3];
    logic [3:0]  mtag[3];
    logic [3:0]  mu_op;
    logic [15:0] mu_a, mu_b;
    logic        mout_valid, merr;
    logic [31:0] mout_res;
    logic [3:0]  mout_tag;
    logic [1:0]  mout_unit;

    // Stub units and run bookkeeping
    bit          ua_act[3];
    int          ua_due[3];
    logic [31:0] ua_res[3];
    int          lat_cfg[3];
    bit          rand_lat;
    logic [2:0]  stall, spur, start_or;
    int          start_cnt, cyc, n_cmp, n_bad;
    int          out_tags[$];
    int          out_units[$];
    logic [31:0] out_res_log[$];

    function automatic int route(logic [1:0] c, logic [3:0] op);
        if (c != 2'd3) return int'(c);
        if (op < 4'd3) return 0;
        if (op < 4'd6) return 1;
        return 2;
    endfunction

    function automatic logic [31:0] unit_fn(int u, logic [3:0] op, logic [15:0] a, logic [15:0] b);
        case (u)
            0:       return {16'h0, a} * {16'h0, b};
            1:       return {16'h0, a} + {16'h0, b};
            default: return {a, b} ^ {28'h0, op};
        endcase
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_step();
        int   t, h;
        bit   acc, disp, ret;
        req_t hd;
        if (rst) begin
            mq.delete(); mord.delete();
            mpend = '0; mhave = '0; mu_start = '0; mu_op = '0; mu_a = '0; mu_b = '0;
            mout_valid = 1'b0; mout_res = '0; mout_tag = '0; mout_unit = '0; merr = 1'b0;
            return;
        end
        acc  = in_valid && (mq.size() < QDEPTH);
        disp = 1'b0;
        t    = 0;
        if (mq.size() > 0) begin
            hd   = mq[0];
            t    = route(hd.cond, hd.op);
            disp = !mpend[t] && !u_busy[t] && (mord.size() < 4);
        end
        ret = 1'b0;
        h   = 0;
        if (mord.size() > 0) begin
            h   = mord[0];
            ret = mhave[h] && (!mout_valid || out_ready);
        end
        for (int i = 0; i < 3; i++) begin
            if (u_done[i]) begin
                if (mpend[i] && !mhave[i]) begin
                    mhold[i] = u_result[i*RES_W +: RES_W];
                    mhave[i] = 1'b1;
                end else begin
                    merr = 1'b1;
                end
            end
        end
        if (ret) begin
            mout_valid = 1'b1; mout_res = mhold[h]; mout_tag = mtag[h]; mout_unit = 2'(h);
            mpend[h] = 1'b0; mhave[h] = 1'b0;
            void'(mord.pop_front());
        end else if (mout_valid && out_ready) begin
            mout_valid = 1'b0;
        end
        mu_start = '0;
        if (disp) begin
            mu_start[t] = 1'b1; mu_op = hd.op; mu_a = hd.a; mu_b = hd.b;
            mpend[t] = 1'b1; mtag[t] = hd.tag;
            mord.push_back(t);
            void'(mq.pop_front());
        end
        if (acc) mq.push_back('{in_cond_sel, in_opcode, in_a, in_b, in_tag});
    endtask

    task automatic compare_all();
        chk("in_ready",   in_ready,   mq.size() < QDEPTH);
        chk("q_count",    q_count,    mq.size());
        chk("u_start",    u_start,    mu_start);
        chk("u_opcode",   u_opcode,   mu_op);
        chk("u_a",        u_a,        mu_a);
        chk("u_b",        u_b,        mu_b);
        chk("out_valid",  out_valid,  mout_valid);
        chk("out_result", out_result, mout_res);
        chk("out_tag",    out_tag,    mout_tag);
        chk("out_unit",   out_unit,   mout_unit);
        chk("busy",       busy,       (mq.size() != 0) || (mpend != 0) || mout_valid);
        chk("err",        err_spurious, merr);
    endtask

    task automatic cycle();
        u_done   = spur;
        u_result = '0;
        u_busy   = stall;
        for (int i = 0; i < 3; i++) begin
            if (ua_act[i] && ua_due[i] == cyc + 1) begin
                u_done[i] = 1'b1;
                u_result[i*RES_W +: RES_W] = ua_res[i];
            end
            if (ua_act[i]) u_busy[i] = 1'b1;
        end
        model_step();
        @(posedge clk);
        cyc++;
        #1;
        for (int i = 0; i < 3; i++) begin
            if (ua_act[i] && ua_due[i] == cyc) ua_act[i] = 1'b0;
            if (mu_start[i]) begin
                ua_act[i] = 1'b1;
                ua_due[i] = cyc + 1 + (rand_lat ? int'($urandom_range(1, 6)) : lat_cfg[i]);
                ua_res[i] = unit_fn(i, mu_op, mu_a, mu_b);
            end
        end
        compare_all();
        start_or |= u_start;
        if (u_start != 3'b000) start_cnt++;
        if (out_valid) begin
            out_tags.push_back(int'(out_tag));
            out_units.push_back(int'(out_unit));
            out_res_log.push_back(out_result);
        end
        @(negedge clk);
        spur = '0;
    endtask

    task automatic send(input logic [1:0] c, input logic [3:0] op, input logic [15:0] a,
                        input logic [15:0] b, input logic [3:0] tag);
        in_valid = 1'b1; in_cond_sel = c; in_opcode = op; in_a = a; in_b = b; in_tag = tag;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input bit clear_units);
        rst = 1'b1;
        if (clear_units) for (int i = 0; i < 3; i++) ua_act[i] = 1'b0;
        cycle();
        cycle();
        rst = 1'b0;
    endtask

    task automatic clear_logs();
        start_or = '0; start_cnt = 0;
        out_tags.delete(); out_units.delete(); out_res_log.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int tagc;
        n_cmp = 0; n_bad = 0; cyc = 0; tagc = 0;
        rst = 1'b1; in_valid = 1'b1; in_cond_sel = '0; in_opcode = '0;
        in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
        stall = '0; spur = '0; rand_lat = 1'b0;
        u_done = '0; u_busy = '0; u_result = '0;
        for (int i = 0; i < 3; i++) begin
            ua_act[i] = 1'b0; ua_due[i] = 0; ua_res[i] = '0; lat_cfg[i] = 1;
            mhold[i] = '0; mtag[i] = '0;
        end
        mpend = '0; mhave = '0; mu_start = '0; mout_valid = 1'b0; merr = 1'b0;
        clear_logs();

        // Reset held with in_valid asserted
        cycle();
        cycle();
        chk("rst_in_ready",  in_ready,  1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_q_count",   q_count,   0);
        chk("rst_u_start",   u_start,   0);
        chk("rst_busy",      busy,      0);
        rst = 1'b0; in_valid = 1'b0;

        // Single op routed by opcode to unit 1
        clear_logs();
        send(2'd3, 4'd4, 16'h0012, 16'h0034, 4'd5);
        for (int k = 0; k < 12; k++) cycle();
        chk("single_start_cnt", start_cnt, 1);
        chk("single_start_vec", start_or, 3'b010);
        chk("single_out_cnt",   out_tags.size(), 1);
        if (out_tags.size() > 0) begin
            chk("single_result", out_res_log[0], 32'h0000_0046);
            chk("single_tag",    out_tags[0],    5);
            chk("single_unit",   out_units[0],   1);
        end

        // Reorder: slow unit 0 issued before fast unit 2
        clear_logs();
        lat_cfg[0] = 8; lat_cfg[2] = 1;
        send(2'd0, 4'd0, 16'h0003, 16'h0005, 4'd1);
        send(2'd2, 4'd0, 16'h0007, 16'h0009, 4'd2);
        for (int k = 0; k < 25; k++) cycle();
        chk("reorder_starts", start_or, 3'b101);
        chk("reorder_cnt",    out_tags.size(), 2);
        if (out_tags.size() == 2) begin
            chk("reorder_tag0", out_tags[0], 1);
            chk("reorder_tag1", out_tags[1], 2);
            chk("reorder_res0", out_res_log[0], 32'h0000_000f);
            chk("reorder_res1", out_res_log[1], 32'h0007_0009);
        end

        // Backpressure on the output register
        lat_cfg[0] = 1; lat_cfg[2] = 1;
        out_ready = 1'b0;
        send(2'd1, 4'd9, 16'h0020, 16'h0022, 4'd7);
        for (int k = 0; k < 20 && !out_valid; k++) cycle();
        chk("bp_valid_seen", out_valid, 1);
        for (int k = 0; k < 5; k++) begin
            cycle();
            chk("bp_valid",  out_valid,  1);
            chk("bp_result", out_result, 32'h0000_0042);
            chk("bp_tag",    out_tag,    7);
            chk("bp_unit",   out_unit,   1);
        end
        out_ready = 1'b1;
        cycle();
        chk("bp_drop", out_valid, 0);

        // Queue fill behind a unit that never completes
        lat_cfg[0] = 1000000;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            in_valid = 1'b1; in_cond_sel = 2'd0; in_opcode = 4'(k);
            in_a = 16'(k); in_b = 16'(k); in_tag = 4'(k);
            if (in_ready) acc++;
            cycle();
        end
        in_valid = 1'b0;
        chk("full_accepts",  acc,      5);
        chk("full_q_count",  q_count,  4);
        chk("full_in_ready", in_ready, 0);
        lat_cfg[0] = 1;
        do_reset(1'b1);

        // Spurious completion on an idle unit
        clear_logs();
        spur = 3'b100;
        cycle();
        cycle();
        chk("spur_err",    err_spurious, 1);
        chk("spur_no_out", out_tags.size(), 0);

        // Reset while two operations are outstanding
        do_reset(1'b1);
        chk("rst2_err", err_spurious, 0);
        lat_cfg[0] = 6; lat_cfg[1] = 6;
        send(2'd0, 4'd1, 16'h0001, 16'h0002, 4'd3);
        send(2'd1, 4'd4, 16'h0003, 16'h0004, 4'd4);
        cycle();
        cycle();
        chk("mid_busy_before", busy, 1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_logs();
        for (int k = 0; k < 15; k++) cycle();
        chk("mid_no_out", out_tags.size(), 0);
        chk("mid_busy",   busy,         0);
        chk("mid_q",      q_count,      0);
        chk("mid_err",    err_spurious, 1);

        // Randomized traffic
        do_reset(1'b1);
        rand_lat = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            in_valid    = ($urandom_range(0, 9) < 6);
            in_cond_sel = 2'($urandom_range(0, 3));
            in_opcode   = 4'($urandom_range(0, 15));
            in_a        = 16'($urandom);
            in_b        = 16'($urandom);
            in_tag      = 4'(tagc);
            tagc++;
            out_ready   = ($urandom_range(0, 9) < 7);
            for (int i = 0; i < 3; i++) stall[i] = ($urandom_range(0, 9) == 0);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1; stall = '0;
        for (int k = 0; k < 40; k++) cycle();
        chk("drain_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/radix_dispatcher.md
RADIX_DISPATCHER -- requirements
Module: radix_dispatcher

Interface
REQ-001 SHALL take parameters: DATA_W, default 16, operand width; QDEPTH, default 4, input queue depth (power of two, >=2); TAG_W, default 4, request tag width.
REQ-002 SHALL fix NUM_UNITS=3 and RES_W=2*DATA_W as localparams; unit indices are 0=base-2, 1=base-10, 2=base-12.
REQ-003 clk  in  1  clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  request offered.
REQ-006 in_ready  out  1  request queue not full; combinational from the queue count.
REQ-007 in_cond_sel  in  2  route mode: 0/1/2 force unit 0/1/2; 3 routes by opcode.
REQ-008 in_opcode  in  4; in_a, in_b  in  DATA_W  operands; in_tag  in  TAG_W.
REQ-009 u_start  out  3  one-hot, one-cycle start per unit; u_opcode  out  4; u_a, u_b  out  DATA_W, shared registered broadcast.
REQ-010 u_busy  in  3; u_done  in  3, one-cycle pulses; u_result  in  3*RES_W, with unit i at bits [i*RES_W +: RES_W].
REQ-011 out_valid  out  1; out_ready  in  1; out_result  out  RES_W; out_tag  out  TAG_W; out_unit  out  2.
REQ-012 q_count  out  $clog2(QDEPTH)+1  queue occupancy; busy  out  1; err_spurious  out  1  sticky.

Function
REQ-013 Routing for cond_sel=3 SHALL be: opcode 0-2 goes to unit 0, 3-5 to unit 1, and 6-15 to unit 2.
REQ-014 Routing SHALL be computed from the queued fields at the queue head, not from the live inputs.
REQ-015 A request SHALL be accepted on an edge where in_valid && in_ready; the write goes into a circular FIFO of QDEPTH entries, with pointers wrapping modulo QDEPTH.
REQ-016 Dispatch SHALL occur when all of these hold: the queue is non-empty, the head's target t has pending[t]=0 and u_busy[t]=0, and the order FIFO is not full.
REQ-017 On dispatch, the block SHALL register u_start[t]=1 for exactly one cycle, register u_opcode/u_a/u_b from the head, set pending[t], store the head tag in tag_reg[t], push t into the order FIFO (depth 4), and pop the queue.
REQ-018 Issue SHALL be strictly in order: a head whose unit is pending blocks the queue (no bypass), and at most one dispatch happens per cycle.
REQ-019 Units SHALL run concurrently, with up to 3 outstanding operations and at most one per unit.
REQ-020 A u_done[i] pulse with pending[i]=1 SHALL capture u_result slice i into hold[i] and set have[i].
REQ-021 A u_done[i] pulse with pending[i]=0 or have[i]=1 SHALL be ignored and SHALL set err_spurious (cleared only by rst).
REQ-022 Retire SHALL occur when the order-FIFO head h has have[h]=1 and (out_valid=0 or out_ready=1).
REQ-023 Retire SHALL load out_result=hold[h], out_tag=tag_reg[h], out_unit=h, set out_valid=1, clear pending[h] and have[h], and pop the order FIFO.
REQ-024 Results SHALL leave strictly in issue order; a later-issued unit that finishes early SHALL hold its result until it reaches the order-FIFO head.
REQ-025 When out_valid=1 and out_ready=1 and nothing retires, out_valid SHALL drop to 0.
REQ-026 While out_valid=1 and out_ready=0, out_result, out_tag and out_unit SHALL be held stable.
REQ-027 Latency, with an empty queue and an idle unit: accept at edge k, u_start high during cycle k+1..k+2.
REQ-028 Latency, result path: u_done sampled at edge d gives out_valid=1 from edge d+1, provided h is at the order-FIFO head and the output is free.
REQ-029 A unit freed by retire at edge r SHALL be dispatchable no earlier than edge r+1.
REQ-030 Accept and dispatch in the same cycle SHALL both occur, leaving q_count unchanged; when full, in_ready=0 and in_valid SHALL be ignored.
REQ-031 busy SHALL be 1 whenever the queue is non-empty, any pending bit is set, or out_valid=1.

Reset
REQ-032 On rst=1 at an edge, the block SHALL clear the queue, order FIFO, pending, have, u_start, out_valid and err_spurious.
REQ-033 On rst=1 at an edge, the block SHALL zero u_opcode, u_a, u_b, out_result, out_tag, out_unit and q_count, and set busy=0.
REQ-034 After reset, in_ready SHALL be 1.
REQ-035 rst SHALL take priority over every simultaneous event; operations in flight are discarded, and later u_done pulses for them set err_spurious.

Verification
REQ-036 Reset: assert rst for 2 cycles with in_valid=1 -> in_ready=1, out_valid=0, q_count=0, u_start=000, busy=0.
REQ-037 Single op: cond_sel=3, opcode=4, a=0x0012, b=0x0034, tag=5, unit 1 model returns 0x00000046 after 1 cycle -> u_start=010 for one cycle; out_result=0x46, out_tag=5, out_unit=1.
REQ-038 Reorder: op A (cond_sel=0, tag=1, unit 0 latency 8) then op B (cond_sel=2, tag=2, unit 2 latency 1) -> both units started; out_tag order is 1 then 2; B is held until A retires.
REQ-039 Full: cond_sel=0 on all requests, unit 0 never done, 6 offers -> 5 accepted (1 dispatched, 4 queued); q_count=4, in_ready=0; the 6th request is not enqueued.
REQ-040 Backpressure: hold out_ready=0 for 5 cycles with out_valid=1 -> outputs stable; then out_ready=1 -> out_valid drops the next edge.
REQ-041 Spurious and reset-mid-op: pulse u_done[2] with no pending op -> err_spurious=1 and no output; assert rst while 2 ops are outstanding -> all cleared, and no out_valid follows.
